eth_manchester_encoder: RTL and testbench

//  Downstream of the Ethernet serialiser. Consumes its 10 Mbit/s bit stream (tx_sck/tx_mosi)
//  and produces 10BASE-T line signalling for the twisted-pair driver:
//  - Manchester-coded data.
//  - The TP_IDL end-of-transmission delimiter.
//  - Normal link pulses (NLP) while idle.

---
 rtl/eth_tx_pkg.sv | 7 +
 rtl/eth_nlp_timer.sv | 19 +
 rtl/eth_manchester_encoder.sv | 97 +++++++++
 tb/tb_eth_manchester_encoder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared state encoding and default timing constants for the 10BASE-T transmit path.
package eth_tx_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, NLP = 2'd1, DATA = 2'd2, ETD = 2'd3} state_t;
   localparam int TP_IDL_CYCLES_DEF = 6;
   localparam int NLP_PERIOD_DEF    = 320000;
   localparam int NLP_WIDTH_DEF     = 2;
endpackage

// File: rtl/eth_nlp_timer.sv
// eth_nlp_timer: free-running link-pulse period counter, held at 0 by hold, strobes start at count 0.
module eth_nlp_timer import eth_tx_pkg::*; #(
   parameter int NLP_PERIOD = NLP_PERIOD_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic hold,
   output logic start
);
   localparam int W = $clog2(NLP_PERIOD);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = (hold || cnt_q == W'(NLP_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      start = ~hold & (cnt_q == '0);
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/eth_manchester_encoder.sv
// eth_manchester_encoder: Manchester data, TP_IDL delimiter and (with ETH_NLP_EN) normal link pulses
// for a 10BASE-T line driver, fed by the serialiser's tx_sck/tx_mosi stream.
module eth_manchester_encoder import eth_tx_pkg::*; #(
   parameter int TP_IDL_CYCLES = TP_IDL_CYCLES_DEF,
   parameter int NLP_PERIOD    = NLP_PERIOD_DEF,
   parameter int NLP_WIDTH     = NLP_WIDTH_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic tx_sck,
   input  logic tx_mosi,
   output logic td_p,
   output logic td_n,
   output logic td_oe,
   output logic tx_active
);
`ifdef ETH_NLP_EN
   localparam int CW = $clog2((TP_IDL_CYCLES > NLP_WIDTH ? TP_IDL_CYCLES : NLP_WIDTH) + 1);
   logic nlp_start;
`else
   localparam int CW = $clog2(TP_IDL_CYCLES + 1);
   logic unused_nlp;
   assign unused_nlp = ^{NLP_PERIOD, NLP_WIDTH};
`endif
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_qq, mosi_q, bit_q, bit_d, ph_q, ph_d, ev;
   assign ev = sck_q & ~sck_qq;
   // An edge event always (re)starts a bit, overriding a link pulse or the delimiter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      if (ev) begin
         state_d = DATA;
         ph_d    = 1'b0;
         bit_d   = mosi_q;
      end else begin
         case (state_q)
            DATA: begin
               ph_d = 1'b1;
               if (ph_q) begin
                  state_d = ETD;
                  cnt_d   = '0;
               end
            end
            ETD: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(TP_IDL_CYCLES - 1)) state_d = IDLE;
            end
`ifdef ETH_NLP_EN
            NLP: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(NLP_WIDTH - 1)) state_d = IDLE;
            end
            default: if (nlp_start) begin
               state_d = NLP;
               cnt_d   = '0;
            end
`else
            default: state_d = IDLE;
`endif
         endcase
      end
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         bit_q   <= 1'b0;
         sck_q   <= 1'b0;
         sck_qq  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         sck_q   <= tx_sck;
         sck_qq  <= sck_q;
         mosi_q  <= tx_mosi;
      end
   assign tx_active = state_q == DATA || state_q == ETD;
   assign td_oe     = state_q != IDLE;
   assign td_p      = state_q == DATA ? (ph_q ? bit_q : ~bit_q) : td_oe;
   assign td_n      = td_oe & ~td_p;
`ifdef ETH_NLP_EN
   eth_nlp_timer #(.NLP_PERIOD(NLP_PERIOD)) u_nlp (
      .clk   (clk),
      .n_rst (n_rst),
      .hold  (tx_active),
      .start (nlp_start)
   );
`endif
endmodule

// File: tb/tb_eth_manchester_encoder.sv
// tb_eth_manchester_encoder: table-driven 8'hA5 frame, hand corner sequences and random frames
// checked against a cycle-offset model of the line signalling.
module tb_eth_manchester_encoder;
`ifdef ETH_NLP_EN
   localparam bit NLP_EN = 1'b1;
`else
   localparam bit NLP_EN = 1'b0;
`endif
   localparam int PER = 20;
   logic clk = 1'b0, n_rst, tx_sck, tx_mosi;
   logic td_p, td_n, td_oe, tx_active;
   always #5 clk = ~clk;
   eth_manchester_encoder #(.TP_IDL_CYCLES(6), .NLP_PERIOD(PER), .NLP_WIDTH(2)) dut (
      .clk(clk), .n_rst(n_rst), .tx_sck(tx_sck), .tx_mosi(tx_mosi),
      .td_p(td_p), .td_n(td_n), .td_oe(td_oe), .tx_active(tx_active)
   );
   typedef struct {bit sck; bit mosi; bit p; bit oe; bit act; bit chk;} vec_t;
   vec_t tbl[24];
   int cyc = 0, base = 0, last_e = -1, passed = 0, total = 0;
   bit last_b, prev_s;
   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s cyc=%0d got {p,n,oe,act}=%b want=%b", name, cyc, got, exp);
   endtask
   // Line state from the distance to the most recent edge event: 2 half-bits, 6 TP_IDL
   // cycles, then idle with link pulses 1..2 cycles after each period boundary.
   function automatic logic [3:0] model(input int c);
      int d, k;
      bit p, oe;
      d = (last_e >= 0) ? c - last_e : 1 << 30;
      k = c - ((last_e >= 0) ? last_e + 9 : base);
      if (d <= 2) begin
         p  = (d == 1) ? ~last_b : last_b;
         oe = 1'b1;
      end else if (d <= 8) begin
         p  = 1'b1;
         oe = 1'b1;
      end else begin
         oe = NLP_EN && (k % PER == 1 || k % PER == 2);
         p  = oe;
      end
      return {p, oe & ~p, oe, d <= 8};
   endfunction
   task automatic tick(input bit s, input bit m);
      tx_sck  = s;
      tx_mosi = m;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check("model", {td_p, td_n, td_oe, tx_active}, model(cyc));
      if (s && !prev_s) begin
         last_e = cyc;
         last_b = m;
      end
      prev_s = s;
   endtask
   task automatic release_rst();
      n_rst  = 1'b1;
      base   = cyc;
      last_e = -1;
      prev_s = 1'b0;
   endtask
   initial begin
      tbl[0]  = '{1, 1, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 1, 1, 1};
      tbl[2]  = '{1, 0, 1, 1, 1, 1};
      tbl[3]  = '{0, 0, 1, 1, 1, 1};
      tbl[4]  = '{1, 1, 0, 1, 1, 1};
      tbl[5]  = '{0, 1, 0, 1, 1, 1};
      tbl[6]  = '{1, 0, 1, 1, 1, 1};
      tbl[7]  = '{0, 0, 1, 1, 1, 1};
      tbl[8]  = '{1, 0, 0, 1, 1, 1};
      tbl[9]  = '{0, 0, 1, 1, 1, 1};
      tbl[10] = '{1, 1, 0, 1, 1, 1};
      tbl[11] = '{0, 1, 0, 1, 1, 1};
      tbl[12] = '{1, 0, 1, 1, 1, 1};
      tbl[13] = '{0, 0, 1, 1, 1, 1};
      tbl[14] = '{1, 1, 0, 1, 1, 1};
      tbl[15] = '{0, 1, 0, 1, 1, 1};
      for (int i = 16; i < 23; i++) tbl[i] = '{0, 0, 1, 1, 1, 1};
      tbl[23] = '{0, 0, 0, 0, 0, 1};
      n_rst   = 1'b0;
      tx_sck  = 1'b0;
      tx_mosi = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", {td_p, td_n, td_oe, tx_active}, 4'b0000);
      release_rst();
      for (int i = 0; i < 24; i++) begin
         tick(tbl[i].sck, tbl[i].mosi);
         if (tbl[i].chk)
            check($sformatf("a5_vec%0d", i), {td_p, td_n, td_oe, tx_active},
                  {tbl[i].p, tbl[i].oe & ~tbl[i].p, tbl[i].oe, tbl[i].act});
      end
      repeat (45) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b1);
      #2 n_rst = 1'b0;
      #1 check("async_rst", {td_p, td_n, td_oe, tx_active}, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hold", {td_p, td_n, td_oe, tx_active}, 4'b0000);
      release_rst();
      repeat (5) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0);
         check("b2b_active", {3'b000, tx_active}, 4'b0001);
      end
      tick(1'b1, 1'b1);
      check("b2b_etd3", {3'b000, tx_active}, 4'b0001);
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b1);
         check("b2b_resume", {3'b000, tx_active}, 4'b0001);
      end
      repeat (12) tick(1'b0, 1'b0);
      for (int f = 0; f < 40; f++) begin
         int nb, gap;
         nb  = $urandom_range(1, 10);
         gap = $urandom_range(1, 30);
         for (int j = 0; j < nb; j++) begin
            bit m;
            m = 1'($urandom);
            tick(1'b1, m);
            tick(1'b0, m);
         end
         repeat (gap) tick(1'b0, 1'($urandom));
      end
      repeat (1000) tick(1'b0, 1'($urandom));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
